// File: rtl/pio_fifo_pair.sv
// Paired TX/RX first-word-fall-through FIFOs sharing two storage banks, joinable for double depth.
// Pushes are visible at dout one cycle later; a push while full or a pull while empty is refused and flagged.
module pio_fifo_pair #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH) + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             join_tx,
  input  logic             join_rx,
  input  logic             tx_push,
  input  logic [WIDTH-1:0] tx_din,
  input  logic             tx_pull,
  output logic [WIDTH-1:0] tx_dout,
  output logic             tx_empty,
  output logic             tx_full,
  output logic [LW-1:0]    tx_level,
  input  logic             rx_push,
  input  logic [WIDTH-1:0] rx_din,
  input  logic             rx_pull,
  output logic [WIDTH-1:0] rx_dout,
  output logic             rx_empty,
  output logic             rx_full,
  output logic [LW-1:0]    rx_level,
  input  logic [3:0]       flags_clr,
  output logic [3:0]       flags
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_TXJ  = 2'd1;
  localparam logic [1:0] MODE_RXJ  = 2'd2;
  localparam logic [LW-1:0] CAP_ONE = LW'(DEPTH);
  localparam logic [LW-1:0] CAP_TWO = LW'(2 * DEPTH);

  logic [WIDTH-1:0] r_mem [2*DEPTH];
  logic [1:0]       r_mode;
  logic [LW-1:0]    r_tx_level, r_rx_level;
  logic [PW-1:0]    r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [3:0]       r_flags;

  logic [1:0]       w_mode;
  logic             w_flush;
  logic [LW-1:0]    w_tx_cap, w_rx_cap;
  logic [PW-1:0]    w_rx_base, w_rx_waddr, w_rx_raddr;
  logic             w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic             w_tx_do_push, w_tx_do_pull, w_rx_do_push, w_rx_do_pull;
  logic             w_tx_over, w_tx_under, w_rx_over, w_rx_under;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p, input logic [LW-1:0] cap);
    return ({1'b0, p} == cap - LW'(1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_mode = MODE_NONE;
    if (join_tx)      w_mode = MODE_TXJ;
    else if (join_rx) w_mode = MODE_RXJ;
    w_flush = (w_mode != r_mode);

    // Capacity follows the registered mode, so a join takes effect after its flush cycle.
    w_tx_cap = CAP_ONE;
    w_rx_cap = CAP_ONE;
    case (r_mode)
      MODE_TXJ: begin w_tx_cap = CAP_TWO; w_rx_cap = '0; end
      MODE_RXJ: begin w_tx_cap = '0;      w_rx_cap = CAP_TWO; end
      default:  ;
    endcase
  end

  assign w_rx_base  = (r_mode == MODE_NONE) ? PW'(DEPTH) : '0;
  assign w_rx_waddr = w_rx_base + r_rx_wptr;
  assign w_rx_raddr = w_rx_base + r_rx_rptr;

  assign w_tx_empty = (r_tx_level == '0);
  assign w_tx_full  = (r_tx_level == w_tx_cap);
  assign w_rx_empty = (r_rx_level == '0);
  assign w_rx_full  = (r_rx_level == w_rx_cap);

  assign w_tx_do_push = tx_push & ~w_tx_full  & ~w_flush;
  assign w_tx_do_pull = tx_pull & ~w_tx_empty & ~w_flush;
  assign w_rx_do_push = rx_push & ~w_rx_full  & ~w_flush;
  assign w_rx_do_pull = rx_pull & ~w_rx_empty & ~w_flush;

  assign w_tx_over  = tx_push & w_tx_full  & ~w_flush;
  assign w_tx_under = tx_pull & w_tx_empty & ~w_flush;
  assign w_rx_over  = rx_push & w_rx_full  & ~w_flush;
  assign w_rx_under = rx_pull & w_rx_empty & ~w_flush;

  always_ff @(posedge clk) begin
    if (w_tx_do_push) r_mem[r_tx_wptr]  <= tx_din;
    if (w_rx_do_push) r_mem[w_rx_waddr] <= rx_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode     <= MODE_NONE;
      r_tx_level <= '0;
      r_rx_level <= '0;
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_flags    <= '0;
    end else begin
      r_mode  <= w_mode;
      r_flags <= (r_flags & ~flags_clr) | {w_rx_under, w_rx_over, w_tx_under, w_tx_over};
      if (w_flush) begin
        r_tx_level <= '0;
        r_rx_level <= '0;
        r_tx_wptr  <= '0;
        r_tx_rptr  <= '0;
        r_rx_wptr  <= '0;
        r_rx_rptr  <= '0;
      end else begin
        if (w_tx_do_push) r_tx_wptr <= f_next(r_tx_wptr, w_tx_cap);
        if (w_tx_do_pull) r_tx_rptr <= f_next(r_tx_rptr, w_tx_cap);
        if (w_rx_do_push) r_rx_wptr <= f_next(r_rx_wptr, w_rx_cap);
        if (w_rx_do_pull) r_rx_rptr <= f_next(r_rx_rptr, w_rx_cap);
        if (w_tx_do_push & ~w_tx_do_pull)      r_tx_level <= r_tx_level + LW'(1);
        else if (~w_tx_do_push & w_tx_do_pull) r_tx_level <= r_tx_level - LW'(1);
        if (w_rx_do_push & ~w_rx_do_pull)      r_rx_level <= r_rx_level + LW'(1);
        else if (~w_rx_do_push & w_rx_do_pull) r_rx_level <= r_rx_level - LW'(1);
      end
    end
  end

  assign tx_dout  = r_mem[r_tx_rptr];
  assign rx_dout  = r_mem[w_rx_raddr];
  assign tx_empty = w_tx_empty;
  assign tx_full  = w_tx_full;
  assign tx_level = r_tx_level;
  assign rx_empty = w_rx_empty;
  assign rx_full  = w_rx_full;
  assign rx_level = r_rx_level;
  assign flags    = r_flags;

endmodule
